bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL have parameter MIN_DIGITS, default 2: number of BCD minute digits (1..4); maximum minutes MAXM = 10^MIN_DIGITS-1.
REQ-002 The block SHALL have parameter LONG_MIN, default 5: firm asserts when set minutes >= LONG_MIN.
REQ-003 The block SHALL have parameter ALARM_TICKS, default 10: number of 1 Hz ticks spent in EXPIRED.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all logic in this domain.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port tick_1hz, input, 1 bit: one-clk pulse per second.
REQ-007 The block SHALL have port cook_time, input, 1 bit: level; enables time setting.
REQ-008 The block SHALL have ports min_inc, sec_inc, start and clear, each input, 1 bit: debounced one-clk pulses.
REQ-009 The block SHALL have port count_up, input, 1 bit: level; 1 = stopwatch mode, 0 = countdown mode; sampled only on the IDLE->RUN transition.
REQ-010 The block SHALL have port sec_bcd, output, 8 bits: {tens, ones} BCD seconds.
REQ-011 The block SHALL have port min_bcd, output, 4*MIN_DIGITS bits: BCD minutes, least significant digit in [3:0].
REQ-012 The block SHALL have ports running, expired, firm and led, each output, 1 bit, registered.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and EXPIRED.
REQ-014 In IDLE with cook_time=1, sec_inc SHALL advance seconds 00->59 and wrap 59->00 with no carry into minutes.
REQ-015 In IDLE with cook_time=1, min_inc SHALL advance minutes and wrap MAXM->0.
REQ-016 min_inc and sec_inc in the same cycle SHALL both take effect; both SHALL be ignored outside IDLE or when cook_time=0.
REQ-017 In IDLE, start SHALL move the FSM to RUN, except in countdown mode when the time is 00:00, where start SHALL be ignored.
REQ-018 In RUN, each tick_1hz SHALL decrement the time in BCD (mm:00 -> (mm-1):59) in countdown mode, or increment it in stopwatch mode (59 s carries into minutes).
REQ-019 In countdown mode, a tick_1hz at 00:01 SHALL make the time 00:00 and move the FSM to EXPIRED on the same edge.
REQ-020 In stopwatch mode, a tick_1hz at MAXM:59 SHALL hold the time and move the FSM to EXPIRED.
REQ-021 start in RUN SHALL move the FSM to PAUSE; start in PAUSE SHALL move it to RUN; time SHALL be frozen in PAUSE.
REQ-022 In EXPIRED, led SHALL toggle on each tick_1hz; after ALARM_TICKS ticks the FSM SHALL return to IDLE with led=0 and the time held.
REQ-023 clear in any state SHALL zero the time, set led=0 and move the FSM to IDLE on the next edge.
REQ-024 Priority SHALL be clear > start > tick_1hz; start and tick_1hz in the same RUN cycle SHALL pause the timer and drop the tick.
REQ-025 running SHALL equal (state==RUN); expired SHALL equal (state==EXPIRED); led SHALL be 0 outside EXPIRED.
REQ-026 firm SHALL be registered (minutes >= LONG_MIN), updated every cycle.
REQ-027 Every event SHALL have one-cycle latency: outputs reflect the event after the clk edge that samples it.
REQ-028 BCD digits SHALL never hold values greater than 9; the seconds tens digit SHALL never exceed 5.

Reset
REQ-029 Reset SHALL asynchronously force the time to 00:00, the FSM to IDLE, the alarm counter to 0, and running, expired, led and firm to 0.
REQ-030 Reset asserted mid-RUN or mid-EXPIRED SHALL abort immediately, with no tick or alarm pending after release.

Structure
REQ-031 Package timer_pkg SHALL hold the FSM state enum (2 bits) and the BCD constants BCD_NINE and SEC_TENS_MAX=5.
REQ-032 Sub-module bcd_digit SHALL implement one BCD digit with inc/dec enables, a parameterised wrap limit, and carry/borrow out; it SHALL be instantiated 2+MIN_DIGITS times.

Verification
REQ-033 Scenario: set 01:05 (1 min_inc, 5 sec_inc, cook_time=1), start, 6 ticks -> 00:59, running=1.
REQ-034 Scenario: countdown from 00:02, 2 ticks -> 00:00, expired=1; then 10 ticks -> led toggles 10 times, FSM in IDLE, led=0.
REQ-035 Scenario: start and tick_1hz asserted in the same RUN cycle -> PAUSE, time unchanged; further ticks have no effect until the next start.
REQ-036 Scenario: MIN_DIGITS=1, 10 min_inc from 0 -> minutes=0 (wrap); start at 00:00 in countdown mode -> stays IDLE.
REQ-037 Scenario: stopwatch mode at 98:59 with MIN_DIGITS=2, 61 ticks -> 99:59 held, expired=1.
REQ-038 Scenario: reset pulse mid-RUN at 03:17 -> immediately 00:00, IDLE, all flags 0; firm=0 after reset, firm=1 once minutes are set to 05.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding and BCD digit limits.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with increment/decrement enables, a wrap limit, and carry/borrow out.
// digit_next exposes the value the digit takes on the coming edge.
module bcd_digit
    import timer_pkg::*;
#(
    parameter logic [3:0] LIMIT = BCD_NINE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit,
    output logic [3:0] digit_next,
    output logic       carry,
    output logic       borrow
);

    always_comb begin
        digit_next = digit;
        carry      = 1'b0;
        borrow     = 1'b0;
        if (clr) begin
            digit_next = 4'd0;
        end else if (inc) begin
            carry      = (digit == LIMIT);
            digit_next = carry ? 4'd0 : digit + 4'd1;
        end else if (dec) begin
            borrow     = (digit == 4'd0);
            digit_next = borrow ? LIMIT : digit - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= 4'd0;
        end else begin
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave-style mm:ss timer: set time in IDLE, count down (or up as a stopwatch),
// pause/resume on start, and flash the led for ALARM_TICKS seconds on expiry.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS  = 2,
    parameter int LONG_MIN    = 5,
    parameter int ALARM_TICKS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_1hz,
    input  logic                    cook_time,
    input  logic                    min_inc,
    input  logic                    sec_inc,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    count_up,
    output logic [7:0]              sec_bcd,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic                    running,
    output logic                    expired,
    output logic                    firm,
    output logic                    led
);

    localparam int AW = $clog2(ALARM_TICKS + 1);

    state_t          state, next_state;
    logic [AW-1:0]   alarm_cnt, alarm_next;
    logic            led_next, mode_up, mode_next;

    logic [3:0]      sec_d [2];
    logic [3:0]      sec_n [2];
    logic            sec_carry [2];
    logic            sec_borrow [2];
    logic [3:0]      min_d [MIN_DIGITS];
    logic [3:0]      min_n [MIN_DIGITS];
    logic            min_carry [MIN_DIGITS];
    logic            min_borrow [MIN_DIGITS];
    logic            min_inc_en [MIN_DIGITS];
    logic            min_dec_en [MIN_DIGITS];

    logic            set_en, run_tick, up_en, dn_en;
    logic            time_zero, next_zero, at_max;
    logic [13:0]     min_val_next;

    assign set_en   = (state == IDLE) && cook_time && !clear;
    assign run_tick = (state == RUN) && tick_1hz && !start && !clear;
    assign up_en    = run_tick && mode_up && !at_max;
    assign dn_en    = run_tick && !mode_up;

    bcd_digit #(.LIMIT(BCD_NINE)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(clear),
        .inc((set_en && sec_inc) || up_en), .dec(dn_en),
        .digit(sec_d[0]), .digit_next(sec_n[0]),
        .carry(sec_carry[0]), .borrow(sec_borrow[0])
    );

    bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clear),
        .inc(sec_carry[0]), .dec(sec_borrow[0]),
        .digit(sec_d[1]), .digit_next(sec_n[1]),
        .carry(sec_carry[1]), .borrow(sec_borrow[1])
    );

    // Seconds only carry into minutes while running; setting wraps seconds on their own.
    genvar g;
    generate
        for (g = 0; g < MIN_DIGITS; g++) begin : g_min
            if (g == 0) begin : g_lsd
                assign min_inc_en[g] = (set_en && min_inc) || (up_en && sec_carry[1]);
                assign min_dec_en[g] = sec_borrow[1];
            end else begin : g_upper
                assign min_inc_en[g] = min_carry[g-1];
                assign min_dec_en[g] = min_borrow[g-1];
            end
            bcd_digit #(.LIMIT(BCD_NINE)) u_min (
                .clk(clk), .reset(reset), .clr(clear),
                .inc(min_inc_en[g]), .dec(min_dec_en[g]),
                .digit(min_d[g]), .digit_next(min_n[g]),
                .carry(min_carry[g]), .borrow(min_borrow[g])
            );
            assign min_bcd[4*g +: 4] = min_d[g];
        end
    endgenerate

    assign sec_bcd = {sec_d[1], sec_d[0]};

    always_comb begin
        time_zero    = (sec_d[1] == 4'd0) && (sec_d[0] == 4'd0);
        next_zero    = (sec_n[1] == 4'd0) && (sec_n[0] == 4'd0);
        at_max       = (sec_d[1] == SEC_TENS_MAX) && (sec_d[0] == BCD_NINE);
        min_val_next = 14'd0;
        for (int i = MIN_DIGITS - 1; i >= 0; i--) begin
            if (min_d[i] != 4'd0)     time_zero = 1'b0;
            if (min_n[i] != 4'd0)     next_zero = 1'b0;
            if (min_d[i] != BCD_NINE) at_max    = 1'b0;
            min_val_next = min_val_next * 14'd10 + {10'd0, min_n[i]};
        end
    end

    // Next-state logic; clear outranks start, which outranks the 1 Hz tick.
    always_comb begin
        next_state = state;
        alarm_next = alarm_cnt;
        led_next   = led;
        mode_next  = mode_up;
        if (clear) begin
            next_state = IDLE;
            alarm_next = '0;
            led_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count_up || !time_zero)) begin
                        next_state = RUN;
                        mode_next  = count_up;
                    end
                end
                RUN: begin
                    if (start) begin
                        next_state = PAUSE;
                    end else if (tick_1hz && ((mode_up && at_max) || (!mode_up && next_zero))) begin
                        next_state = EXPIRED;
                        alarm_next = '0;
                        led_next   = 1'b0;
                    end
                end
                PAUSE: begin
                    if (start) next_state = RUN;
                end
                EXPIRED: begin
                    if (tick_1hz) begin
                        if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
                            next_state = IDLE;
                            alarm_next = '0;
                            led_next   = 1'b0;
                        end else begin
                            alarm_next = alarm_cnt + AW'(1);
                            led_next   = !led;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            alarm_cnt <= '0;
            led       <= 1'b0;
            mode_up   <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
            firm      <= 1'b0;
        end else begin
            state     <= next_state;
            alarm_cnt <= alarm_next;
            led       <= led_next;
            mode_up   <= mode_next;
            running   <= (next_state == RUN);
            expired   <= (next_state == EXPIRED);
            firm      <= (min_val_next >= 14'(LONG_MIN));
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven scoreboard bench for bcd_countdown_timer (default build plus a one-minute-digit build).
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, cook_time = 1'b0, min_inc = 1'b0, sec_inc = 1'b0;
    logic       start = 1'b0, clear = 1'b0, count_up = 1'b0;
    logic [7:0] sec_bcd, min_bcd, sec_bcd1;
    logic [3:0] min_bcd1;
    logic       running, expired, firm, led;
    logic       running1, expired1, firm1, led1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic cook, mi, si, st, cl, tk, up;
        int   reps;
        logic [7:0] sec, min;
        logic run, ex, ld;
    } vec_t;

    typedef struct {
        string tag;
        logic [7:0] sec, min;
        logic run, ex, ld;
    } exp_t;

    vec_t table_q[$];
    exp_t sbq[$];

    bcd_countdown_timer dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .cook_time(cook_time),
        .min_inc(min_inc), .sec_inc(sec_inc), .start(start), .clear(clear),
        .count_up(count_up), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .running(running), .expired(expired), .firm(firm), .led(led)
    );

    bcd_countdown_timer #(.MIN_DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .cook_time(cook_time),
        .min_inc(min_inc), .sec_inc(sec_inc), .start(start), .clear(clear),
        .count_up(count_up), .sec_bcd(sec_bcd1), .min_bcd(min_bcd1),
        .running(running1), .expired(expired1), .firm(firm1), .led(led1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cook, mi, si, st, cl, tk, up, input int reps,
                                input logic [7:0] sec, min, input logic run, ex, ld);
        vec_t v;
        v.cook = cook; v.mi = mi; v.si = si; v.st = st; v.cl = cl; v.tk = tk; v.up = up;
        v.reps = reps; v.sec = sec; v.min = min; v.run = run; v.ex = ex; v.ld = ld;
        return v;
    endfunction

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic compare(input string tag, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        compare({e.tag, " sec"}, sec_bcd, e.sec);
        compare({e.tag, " min"}, min_bcd, e.min);
        compare({e.tag, " running"}, {7'd0, running}, {7'd0, e.run});
        compare({e.tag, " expired"}, {7'd0, expired}, {7'd0, e.ex});
        compare({e.tag, " led"}, {7'd0, led}, {7'd0, e.ld});
        compare({e.tag, " firm"}, {7'd0, firm}, {7'd0, (bcd2int(e.min) >= 5)});
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        for (int r = 0; r < v.reps; r++) begin
            cook_time = v.cook; min_inc = v.mi; sec_inc = v.si; start = v.st;
            clear = v.cl; tick_1hz = v.tk; count_up = v.up;
            if (r == v.reps - 1) begin
                e.tag = tag; e.sec = v.sec; e.min = v.min;
                e.run = v.run; e.ex = v.ex; e.ld = v.ld;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            min_inc = 1'b0; sec_inc = 1'b0; start = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
            checkOutput();
        end
    endtask

    initial begin
        //                    cook mi si st cl tk up reps  sec    min   run ex led
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h01, 0, 0, 0));
        table_q.push_back(mk(1, 0, 1, 0, 0, 0, 0,  5, 8'h05, 8'h01, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h05, 8'h01, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  6, 8'h59, 8'h00, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 1,  1, 8'h58, 8'h00, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 1, 0,  1, 8'h58, 8'h00, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  3, 8'h58, 8'h00, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h58, 8'h00, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 8'h57, 8'h00, 1, 0, 0));
        table_q.push_back(mk(1, 1, 1, 0, 0, 0, 0,  1, 8'h57, 8'h00, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 1, 1, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 0, 1, 0, 0, 0, 0,  2, 8'h02, 8'h00, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h02, 8'h00, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  2, 8'h00, 8'h00, 0, 1, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 8'h00, 8'h00, 0, 1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  8, 8'h00, 8'h00, 0, 1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 60, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 1, 1, 0, 0, 0, 0,  1, 8'h01, 8'h01, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(0, 1, 1, 0, 0, 0, 0,  3, 8'h00, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 59, 8'h59, 8'h00, 0, 0, 0));
        table_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 98, 8'h59, 8'h98, 0, 0, 0));
        table_q.push_back(mk(0, 0, 0, 1, 0, 0, 1,  1, 8'h59, 8'h98, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 60, 8'h59, 8'h99, 1, 0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 8'h59, 8'h99, 0, 1, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 1, 0,  3, 8'h59, 8'h99, 0, 1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0));

        @(posedge clk);
        @(posedge clk);
        #1;
        compare("reset sec", sec_bcd, 8'h00);
        compare("reset min", min_bcd, 8'h00);
        compare("reset flags", {4'd0, running, expired, led, firm}, 8'h00);
        reset = 1'b0;

        foreach (table_q[i]) applyStimulus(table_q[i], $sformatf("row%0d", i));

        // Reset pulse while running at 03:17 aborts everything at once.
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0,  3, 8'h00, 8'h03, 0, 0, 0), "set3m");
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 17, 8'h17, 8'h03, 0, 0, 0), "set17s");
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h17, 8'h03, 1, 0, 0), "run317");
        reset = 1'b1;
        #1;
        compare("async rst sec", sec_bcd, 8'h00);
        compare("async rst min", min_bcd, 8'h00);
        compare("async rst flags", {4'd0, running, expired, led, firm}, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 0,  3, 8'h00, 8'h00, 0, 0, 0), "post rst ticks");
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0,  4, 8'h00, 8'h04, 0, 0, 0), "firm 04");
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0,  1, 8'h00, 8'h05, 0, 0, 0), "firm 05");

        // One-digit build: ten minute presses wrap to 0 and start at 00:00 is ignored.
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0), "clr d1");
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 10, 8'h00, 8'h10, 0, 0, 0), "10 min");
        compare("d1 min wrap", {4'd0, min_bcd1}, 8'h00);
        compare("d1 idle", {6'd0, running1, expired1}, 8'h00);
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0,  1, 8'h00, 8'h10, 1, 0, 0), "start 10m");
        compare("d1 start at zero", {6'd0, running1, expired1}, 8'h00);
        compare("d1 min held", {4'd0, min_bcd1}, 8'h00);
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 0,  1, 8'h00, 8'h00, 0, 0, 0), "final clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
